// File: rtl/mem_vector_access_if.sv
// Data-memory port of the vector memory-stage sequencer.
// The master modport is the sequencer side and the slave modport is the memory side.
interface mem_vector_access_if #(
  parameter int N = 8,
  parameter int A = 16
);
  logic         mem_req;
  logic         mem_we;
  logic [A-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/mem_vector_access.sv
// Memory-stage sequencer: serialises one R-lane vector load/store into R
// single-byte memory transactions and stalls the pipeline while they run.
// Optional feature macro: MEM_LANE_MASK_EN adds the LaneMaskM input; lanes
// whose mask bit is 0 are skipped without costing any cycles.
module mem_vector_access #(
  parameter int N = 8,
  parameter int R = 6,
  parameter int A = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                MemReadM,
  input  logic                MemWriteM,
  input  logic [A-1:0]        AddrM,
  input  logic [R-1:0][N-1:0] WriteDataM,
`ifdef MEM_LANE_MASK_EN
  input  logic [R-1:0]        LaneMaskM,
`endif
  mem_vector_access_if.master mem,
  output logic [R-1:0][N-1:0] ReadDataM,
  output logic                StallM
);

  localparam int LW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic                 is_wr_q, is_wr_d;
  logic [A-1:0]         base_q, base_d;
  logic [R-1:0][N-1:0]  wdata_q, wdata_d;
  logic [R-1:0]         mask_q, mask_d;
  logic [R-1:0][N-1:0]  rdata_q, rdata_d;

  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [A-1:0]         mem_addr_q, mem_addr_d;
  logic [N-1:0]         mem_wdata_q, mem_wdata_d;

  logic                 req_s;
  logic [R-1:0]         mask_in_s;
  logic [LW:0]          first_s;
  logic [LW:0]          next_s;
  logic                 stall_s;

  // Lowest enabled lane at or above 'start'; MSB of the result flags that one exists.
  function automatic logic [LW:0] find_lane(input logic [R-1:0] mask, input int start);
    logic [LW:0] res;
    res = {1'b0, {LW{1'b0}}};
    for (int i = R - 1; i >= 0; i--) begin
      if ((i >= start) && mask[i]) begin
        res = {1'b1, LW'(i)};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

`ifdef MEM_LANE_MASK_EN
  assign mask_in_s = LaneMaskM;
`else
  assign mask_in_s = {R{1'b1}};
`endif

  assign req_s = MemReadM | MemWriteM;

  // State register of the sequencer FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latches, lane counter, load vector and registered memory-port outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q      <= {LW{1'b0}};
      is_wr_q     <= 1'b0;
      base_q      <= {A{1'b0}};
      wdata_q     <= {(R*N){1'b0}};
      mask_q      <= {R{1'b0}};
      rdata_q     <= {(R*N){1'b0}};
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {A{1'b0}};
      mem_wdata_q <= {N{1'b0}};
    end else begin
      lane_q      <= lane_d;
      is_wr_q     <= is_wr_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      rdata_q     <= rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next state, lane stepping, operand capture and load-lane capture.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    is_wr_d = is_wr_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    rdata_d = rdata_q;
    first_s = find_lane(mask_in_s, 0);
    next_s  = find_lane(mask_q, int'(lane_q) + 1);
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          // A simultaneous read and write request is treated as a store.
          is_wr_d = MemWriteM;
          base_d  = AddrM;
          wdata_d = WriteDataM;
          mask_d  = mask_in_s;
          if (!MemWriteM) begin
            rdata_d = {(R*N){1'b0}};
          end else begin
            rdata_d = rdata_q;
          end
          if (first_s[LW]) begin
            state_d = ST_ACCESS;
            lane_d  = first_s[LW-1:0];
          end else begin
            state_d = ST_DONE;
            lane_d  = {LW{1'b0}};
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (mem.mem_ack) begin
          if (!is_wr_q) begin
            rdata_d[lane_q] = mem.mem_rdata;
          end else begin
            rdata_d = rdata_q;
          end
          if (next_s[LW]) begin
            lane_d = next_s[LW-1:0];
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory-port values for the coming cycle, decoded from the next state so
  // the port itself is driven straight from flops; plus the combinational stall.
  always_comb begin
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = {A{1'b0}};
    mem_wdata_d = {N{1'b0}};
    if (state_d == ST_ACCESS) begin
      mem_req_d   = 1'b1;
      mem_we_d    = is_wr_d;
      mem_addr_d  = base_d + A'(lane_d);
      mem_wdata_d = wdata_d[lane_d];
    end else begin
      mem_req_d   = 1'b0;
    end
    // Reset forces the stall low at once even if a request is still presented.
    if (reset) begin
      stall_s = 1'b0;
    end else begin
      stall_s = ((state_q == ST_IDLE) && req_s) || (state_q == ST_ACCESS);
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign ReadDataM     = rdata_q;
  assign StallM        = stall_s;

endmodule

// File: tb/tb_mem_vector_access.sv
// Scoreboard bench for mem_vector_access: expected memory transactions are
// queued when an operation is driven and popped as the DUT acknowledges them.
module tb_mem_vector_access;
  localparam int N = 8;
  localparam int R = 6;
  localparam int A = 16;

  typedef struct packed {
    logic         we;
    logic [A-1:0] addr;
    logic [N-1:0] data;
  } txn_t;

  logic clk = 1'b0;
  logic reset;
  logic MemReadM;
  logic MemWriteM;
  logic [A-1:0] AddrM;
  logic [R-1:0][N-1:0] WriteDataM;
  logic [R-1:0][N-1:0] ReadDataM;
  logic StallM;
`ifdef MEM_LANE_MASK_EN
  logic [R-1:0] LaneMaskM;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int wait_states = 0;
  int wcnt = 0;
  txn_t exp_q[$];
  logic [R-1:0][N-1:0] cur_rd;

  always #5 clk = ~clk;

  mem_vector_access_if #(.N(N), .A(A)) bus ();

  mem_vector_access #(.N(N), .R(R), .A(A)) dut (
    .clk        (clk),
    .reset      (reset),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .AddrM      (AddrM),
    .WriteDataM (WriteDataM),
`ifdef MEM_LANE_MASK_EN
    .LaneMaskM  (LaneMaskM),
`endif
    .mem        (bus.master),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM)
  );

  // Memory contents: 0x10..0x15 hold 01..06, everything else a fixed pattern.
  function automatic logic [N-1:0] init_byte(input logic [A-1:0] a);
    if (a >= 16'h0010 && a <= 16'h0015) return 8'(a - 16'h000F);
    else return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [R-1:0][N-1:0] exp_load(input logic [A-1:0] base, input logic [R-1:0] mask);
    logic [R-1:0][N-1:0] v;
    logic [A-1:0] a;
    for (int i = 0; i < R; i++) begin
      a = base + A'(i);
      v[i] = mask[i] ? init_byte(a) : 8'h00;
    end
    return v;
  endfunction

  assign bus.mem_ack   = bus.mem_req && (wcnt >= wait_states);
  assign bus.mem_rdata = init_byte(bus.mem_addr);

  // Wait-state counter of the memory model.
  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Scoreboard: compare each acknowledged transaction with the queue head.
  initial begin
    txn_t e;
    forever begin
      @(negedge clk);
      if (!reset && bus.mem_req && bus.mem_ack) begin
        if (exp_q.size() == 0) begin
          check_eq("txn_extra", 64'(bus.mem_addr), 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("txn_we", 64'(bus.mem_we), 64'(e.we));
          check_eq("txn_addr", 64'(bus.mem_addr), 64'(e.addr));
          check_eq("txn_wdata", 64'(bus.mem_wdata), 64'(e.data));
        end
      end
    end
  end

  task automatic run_op(input logic rd, input logic wr, input logic [A-1:0] addr,
                        input logic [R-1:0][N-1:0] wdata, input logic [R-1:0] mask,
                        input int waits, input int exp_stall, input string tag);
    txn_t t;
    int stall_cnt;
    int cyc;
    @(negedge clk);
    wait_states = waits;
    MemReadM = rd;
    MemWriteM = wr;
    AddrM = addr;
    WriteDataM = wdata;
`ifdef MEM_LANE_MASK_EN
    LaneMaskM = mask;
`endif
    for (int i = 0; i < R; i++) begin
      if (mask[i]) begin
        t.we = wr;
        t.addr = addr + A'(i);
        t.data = wdata[i];
        exp_q.push_back(t);
      end
    end
    if (!wr) cur_rd = exp_load(addr, mask);
    stall_cnt = 0;
    cyc = 0;
    #1;
    while (StallM === 1'b1 && cyc < 500) begin
      stall_cnt++;
      @(negedge clk);
      #1;
      cyc++;
    end
    check_eq({tag, "_stall"}, 64'(stall_cnt), 64'(exp_stall));
    check_eq({tag, "_rdata"}, 64'(ReadDataM), 64'(cur_rd));
    check_eq({tag, "_req_done"}, 64'(bus.mem_req), 64'd0);
    check_eq({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [R-1:0][N-1:0] st_data;
    logic [R-1:0][N-1:0] st2_data;
    logic [R-1:0][N-1:0] rd_pat;
    st_data  = 48'hFFEEDDCCBBAA;
    st2_data = 48'h112233445566;
    rd_pat   = 48'hC5C4C3C2C1C0;
    cur_rd = '0;
    reset = 1'b1;
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
    AddrM = 16'h0000;
    WriteDataM = '0;
`ifdef MEM_LANE_MASK_EN
    LaneMaskM = 6'b111111;
`endif
    repeat (2) @(negedge clk);
    check_eq("rst_req", 64'(bus.mem_req), 64'd0);
    check_eq("rst_we", 64'(bus.mem_we), 64'd0);
    check_eq("rst_addr", 64'(bus.mem_addr), 64'd0);
    check_eq("rst_wdata", 64'(bus.mem_wdata), 64'd0);
    check_eq("rst_rdata", 64'(ReadDataM), 64'd0);
    check_eq("rst_stall", 64'(StallM), 64'd0);
    reset = 1'b0;

    run_op(1'b1, 1'b0, 16'h0010, '0, 6'b111111, 0, 7, "load0");
    check_eq("load0_vec", 64'(ReadDataM), 64'h060504030201);
    run_op(1'b0, 1'b1, 16'h0100, st_data, 6'b111111, 2, 19, "store2w");
    run_op(1'b1, 1'b0, 16'hFFFD, rd_pat, 6'b111111, 0, 7, "wrap");
    run_op(1'b1, 1'b1, 16'h0200, st2_data, 6'b111111, 1, 13, "both");
    run_op(1'b1, 1'b0, 16'h1234, '0, 6'b111111, 1, 13, "load1w");

    // Reset in the middle of lane 3 of a zero-wait load.
    @(negedge clk);
    wait_states = 0;
    MemReadM = 1'b1;
    AddrM = 16'h0010;
    WriteDataM = '0;
    begin
      txn_t t;
      for (int i = 0; i < R; i++) begin
        t.we = 1'b0;
        t.addr = 16'h0010 + A'(i);
        t.data = 8'h00;
        exp_q.push_back(t);
      end
    end
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_eq("midrst_req", 64'(bus.mem_req), 64'd0);
    check_eq("midrst_stall", 64'(StallM), 64'd0);
    check_eq("midrst_rdata", 64'(ReadDataM), 64'd0);
    check_eq("midrst_lanes_done", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    MemReadM = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run_op(1'b1, 1'b0, 16'h0010, '0, 6'b111111, 0, 7, "after_rst");

`ifdef MEM_LANE_MASK_EN
    run_op(1'b1, 1'b0, 16'h0010, rd_pat, 6'b100101, 0, 4, "mask");
    check_eq("mask_vec", 64'(ReadDataM), 64'h060000030001);
    run_op(1'b0, 1'b1, 16'h0300, st_data, 6'b000000, 0, 1, "mask0");
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
